// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered scan driver for a 3-digit 7-segment display.
// Optional anti-ghosting dead time at the start of every slot: define SEG7_GHOST_BLANK_EN.
module seg7_scan_driver #(
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in_hundreds,
  input  logic [6:0] seg_in_tens,
  input  logic [6:0] seg_in_ones,
  input  logic       update,
  output logic       update_ack,
  output logic [6:0] seg_out,
  output logic [2:0] digit_en,
  output logic       frame_tick
);

  localparam int unsigned     PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [6:0]      SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic [2:0]      DIG_OFF   = {3{DIG_ACTIVE_LOW}};

  typedef enum logic [1:0] {SlotHundreds, SlotTens, SlotOnes} slot_e;

  slot_e         slot_q, slot_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          run_q, run_d;
  logic          pending_q, pending_d;
  logic [6:0]    sh_hun_q, sh_hun_d, sh_ten_q, sh_ten_d, sh_one_q, sh_one_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    dig_q, dig_d;
  logic          ack_q, ack_d;
  logic          tick_q, tick_d;
  logic          boundary;
  logic [6:0]    pattern;
  logic [2:0]    onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= SlotHundreds;
      presc_q   <= '0;
      run_q     <= 1'b0;
      pending_q <= 1'b0;
      sh_hun_q  <= 7'h00;
      sh_ten_q  <= 7'h00;
      sh_one_q  <= 7'h00;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
      ack_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      presc_q   <= presc_d;
      run_q     <= run_d;
      pending_q <= pending_d;
      sh_hun_q  <= sh_hun_d;
      sh_ten_q  <= sh_ten_d;
      sh_one_q  <= sh_one_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      ack_q     <= ack_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    slot_d    = slot_q;
    presc_d   = presc_q;
    run_d     = 1'b1;
    pending_d = pending_q | update;
    sh_hun_d  = sh_hun_q;
    sh_ten_d  = sh_ten_q;
    sh_one_d  = sh_one_q;
    ack_d     = 1'b0;
    tick_d    = 1'b0;
    pattern   = 7'h00;
    onehot    = 3'b000;
    boundary  = run_q && (slot_q == SlotOnes) && (presc_q == PRESC_MAX);

    // The first cycle after reset only arms the scan; counting starts on the next one.
    if (run_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        case (slot_q)
          SlotHundreds: slot_d = SlotTens;
          SlotTens:     slot_d = SlotOnes;
          default:      slot_d = SlotHundreds;
        endcase
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (boundary) begin
      tick_d    = 1'b1;
      pending_d = 1'b0;
      if (pending_q || update) begin
        sh_hun_d = seg_in_hundreds;
        sh_ten_d = seg_in_tens;
        sh_one_d = seg_in_ones;
        ack_d    = 1'b1;
      end
    end

    case (slot_d)
      SlotHundreds: begin pattern = sh_hun_d; onehot = 3'b100; end
      SlotTens:     begin pattern = sh_ten_d; onehot = 3'b010; end
      default:      begin pattern = sh_one_d; onehot = 3'b001; end
    endcase

    seg_d = pattern ^ SEG_OFF;
    dig_d = onehot ^ DIG_OFF;
`ifdef SEG7_GHOST_BLANK_EN
    if (presc_d == '0) begin
      seg_d = SEG_OFF;
      dig_d = DIG_OFF;
    end
`else
`endif
  end

  assign update_ack = ack_q;
  assign frame_tick = tick_q;
  assign seg_out    = seg_q;
  assign digit_en   = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-index reference model.
// Honours SEG7_GHOST_BLANK_EN in the same way as the design.
module tb_seg7_scan_driver;

  localparam int unsigned DIV   = 4;
  localparam int          FRAME = 3 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in_hundreds = 7'h00;
  logic [6:0] seg_in_tens = 7'h00;
  logic [6:0] seg_in_ones = 7'h00;
  logic       update = 1'b0;
  logic       update_ack;
  logic [6:0] seg_out;
  logic [2:0] digit_en;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  // Reference state: m_k = cycle index since reset release, -1 = blank post-reset cycle.
  int         m_k = -1;
  logic [6:0] m_sh [3];
  logic       m_pend = 1'b0;
  logic       m_ack = 1'b0;

  seg7_scan_driver #(
    .CLK_DIV       (DIV),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .seg_in_hundreds(seg_in_hundreds),
    .seg_in_tens    (seg_in_tens),
    .seg_in_ones    (seg_in_ones),
    .update         (update),
    .update_ack     (update_ack),
    .seg_out        (seg_out),
    .digit_en       (digit_en),
    .frame_tick     (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d, t=%0t)", tag, got, exp, m_k, $time);
    end
  endtask

  task automatic check_outputs();
    logic [6:0] e_seg;
    logic [2:0] e_dig;
    logic       e_tick;
    int         slot;
    int         pos;
    if (m_k < 0) begin
      e_seg  = 7'h7F;
      e_dig  = 3'b111;
      e_tick = 1'b0;
    end else begin
      slot   = (m_k / DIV) % 3;
      pos    = m_k % DIV;
      e_seg  = ~m_sh[slot];
      e_dig  = ~(3'b100 >> slot);
      e_tick = (m_k > 0) && (m_k % FRAME == 0);
`ifdef SEG7_GHOST_BLANK_EN
      if (pos == 0) begin
        e_seg = 7'h7F;
        e_dig = 3'b111;
      end
`else
      if (pos < 0) e_seg = 7'h00;
`endif
    end
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("digit_en", 32'(digit_en), 32'(e_dig));
    check("frame_tick", 32'(frame_tick), 32'(e_tick));
    check("update_ack", 32'(update_ack), 32'(m_ack));
  endtask

  // Advance the model across one clock edge using the inputs about to be sampled.
  task automatic model_edge(input logic r, input logic u, input logic [6:0] h,
                            input logic [6:0] t, input logic [6:0] o);
    if (r) begin
      m_k    = -1;
      m_sh   = '{7'h00, 7'h00, 7'h00};
      m_pend = 1'b0;
      m_ack  = 1'b0;
    end else if (m_k < 0) begin
      m_pend = m_pend | u;
      m_ack  = 1'b0;
      m_k    = 0;
    end else begin
      if (m_k % FRAME == FRAME - 1) begin
        m_ack = m_pend | u;
        if (m_ack) m_sh = '{h, t, o};
        m_pend = 1'b0;
      end else begin
        m_pend = m_pend | u;
        m_ack  = 1'b0;
      end
      m_k++;
    end
  endtask

  initial begin
    int         rst_hold = 0;
    logic       r;
    logic       u;
    logic [6:0] h;
    logic [6:0] t;
    logic [6:0] o;
    m_sh = '{7'h00, 7'h00, 7'h00};
    model_edge(1'b1, 1'b0, 7'h00, 7'h00, 7'h00);
    h = 7'h06;
    t = 7'h5B;
    o = 7'h4F;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      check_outputs();
      if (it < 40) begin
        // Directed: update at cycle 5, new digits 1/2/3 shown from cycle 12.
        if (m_k == 12) check("dir_ack12", 32'(update_ack), 32'd1);
        if (m_k == 13) check("dir_hun", 32'(seg_out), 32'h79);
        if (m_k == 17) check("dir_ten", 32'(seg_out), 32'h24);
        if (m_k == 21) check("dir_one", 32'(seg_out), 32'h30);
        r = (it < 2);
        u = (m_k == 5);
      end else begin
        if (rst_hold == 0 && $urandom_range(0, 299) == 0) rst_hold = $urandom_range(1, 3);
        r = (rst_hold > 0);
        if (rst_hold > 0) rst_hold--;
        u = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) h = 7'($urandom);
        if ($urandom_range(0, 3) == 0) t = 7'($urandom);
        if ($urandom_range(0, 3) == 0) o = 7'($urandom);
      end
      rst             = r;
      update          = u;
      seg_in_hundreds = h;
      seg_in_tens     = t;
      seg_in_ones     = o;
      model_edge(r, u, h, t, o);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
